// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial add/sub unit (addsub_serial_nbit).
// Optional build macro used by the top: ADDSUB_SATURATE_EN.
package addsub_pkg;

    // Control states of the serial datapath.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the saturation-limit helpers can describe.
    localparam int SAT_MAX_W = 1024;

    // Two's-complement overflow: operands agree in sign, result disagrees.
    function automatic logic signed_overflow(input logic a_msb,
                                             input logic b_eff_msb,
                                             input logic sum_msb);
        return (a_msb == b_eff_msb) && (sum_msb != a_msb);
    endfunction

    // Most positive value of a 'width'-bit signed number: 0 followed by ones.
    function automatic logic [SAT_MAX_W-1:0] sat_pos_limit(input int width);
        logic [SAT_MAX_W-1:0] ones;
        ones = '1;
        return ones >> (SAT_MAX_W - width + 1);
    endfunction

    // Most negative value of a 'width'-bit signed number: 1 followed by zeros.
    function automatic logic [SAT_MAX_W-1:0] sat_neg_limit(input int width);
        logic [SAT_MAX_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit slice of the serial adder/subtractor.
// b is inverted when inv=1; cin supplies the +1 of the two's complement on
// the first slice and the inter-slice carry afterwards.
module addsub_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         inv,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b ^ {W{inv}}} + {{W{1'b0}}, cin};
    assign s     = total[W-1:0];
    assign cout  = total[W];

endmodule

// File: rtl/addsub_serial_nbit.sv
// Serial WIDTH-bit add/subtract unit, CHUNK bits per clock, valid/ready on
// both sides, with carry/overflow/zero/negative flags.
// Optional build macro: ADDSUB_SATURATE_EN clamps the result to the signed
// limit on overflow (default build wraps modulo 2^WIDTH).
module addsub_serial_nbit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Add_ctrl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             C_out,
    output logic             O,
    output logic             Z,
    output logic             N,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "addsub_serial_nbit: WIDTH must be at least 2");
    end
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $fatal(1, "addsub_serial_nbit: WIDTH must be a multiple of CHUNK");
    end
    if (WIDTH > SAT_MAX_W) begin : g_too_wide
        $fatal(1, "addsub_serial_nbit: WIDTH exceeds SAT_MAX_W");
    end

`ifdef ADDSUB_SATURATE_EN
    localparam logic [SAT_MAX_W-1:0] SAT_POS_FULL = sat_pos_limit(WIDTH);
    localparam logic [SAT_MAX_W-1:0] SAT_NEG_FULL = sat_neg_limit(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_POS      = SAT_POS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_NEG      = SAT_NEG_FULL[WIDTH-1:0];
`endif

    state_t           state;
    logic [WIDTH-1:0] a_q;       // operand A, shifted right one chunk per RUN edge
    logic [WIDTH-1:0] b_q;       // operand B, shifted right one chunk per RUN edge
    logic             inv_q;     // latched Add_ctrl
    logic             carry_q;   // carry between chunks
    logic [IDX_W-1:0] idx;       // chunk being processed

    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_fin;
    logic             ovf;
    logic             last;

    // The current chunk always sits in the low bits of the shifted operands,
    // so one slice adder serves every RUN cycle without a wide input mux.
    addsub_chunk #(.W(CHUNK)) u_chunk (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .inv  (inv_q),
        .cin  (carry_q),
        .s    (chunk_s),
        .cout (chunk_c)
    );

    assign last = (idx == IDX_W'(NCHUNK - 1));

    // Merge the current slice into the result and derive the final-edge flags.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sum_next = SUM;
        sum_next[int'(idx) * CHUNK +: CHUNK] = chunk_s;
        // On the last edge the top chunk is in the low bits of a_q/b_q.
        ovf     = signed_overflow(a_q[CHUNK-1], b_q[CHUNK-1] ^ inv_q, chunk_s[CHUNK-1]);
        sum_fin = sum_next;
`ifdef ADDSUB_SATURATE_EN
        if (ovf) begin
            sum_fin = a_q[CHUNK-1] ? SAT_NEG : SAT_POS;
        end
`endif
    end

    // Control FSM plus operand, carry and registered output updates.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the operand registers are plain flops, not a memory, so clearing them here costs nothing.
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            inv_q     <= 1'b0;
            carry_q   <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            SUM       <= '0;
            C_out     <= 1'b0;
            O         <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        inv_q    <= Add_ctrl;
                        carry_q  <= Add_ctrl;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= chunk_c;
                    if (last) begin
                        idx       <= '0;
                        SUM       <= sum_fin;
                        C_out     <= chunk_c;
                        O         <= ovf;
                        Z         <= (sum_fin == '0);
                        N         <= sum_fin[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                        SUM <= sum_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial_nbit.sv
// Directed bench for addsub_serial_nbit: a 16/4 instance for the main
// vectors and a 32/32 instance for the single-chunk configuration.
// Expected values follow ADDSUB_SATURATE_EN when the bench is built with it.
module tb_addsub_serial_nbit;

    logic clk = 1'b0;
    logic rst;

    // 16-bit, 4-bit chunk instance
    logic [15:0] a, b, sum;
    logic        ctrl, in_valid, in_ready, c_out, ovf, zero, neg, out_valid, out_ready;

    // 32-bit, single-chunk instance
    logic [31:0] a1, b1, sum1;
    logic        ctrl1, iv1, ir1, c1, o1, z1, n1, ov1, or1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addsub_serial_nbit #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .Add_ctrl(ctrl),
        .in_valid(in_valid), .in_ready(in_ready), .SUM(sum), .C_out(c_out),
        .O(ovf), .Z(zero), .N(neg), .out_valid(out_valid), .out_ready(out_ready)
    );

    addsub_serial_nbit #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Add_ctrl(ctrl1),
        .in_valid(iv1), .in_ready(ir1), .SUM(sum1), .C_out(c1),
        .O(o1), .Z(z1), .N(n1), .out_valid(ov1), .out_ready(or1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted; returns just after the accepting edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        check("start.in_ready", 32'(in_ready), 32'd1);
        a = av; b = bv; ctrl = cv; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] es,
                                input logic ec, input logic eo, input logic ez, input logic en);
        check({tag, ".sum"}, 32'(sum), 32'(es));
        check({tag, ".c"}, 32'(c_out), 32'(ec));
        check({tag, ".o"}, 32'(ovf), 32'(eo));
        check({tag, ".z"}, 32'(zero), 32'(ez));
        check({tag, ".n"}, 32'(neg), 32'(en));
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".ack_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".ack_valid"}, 32'(out_valid), 32'd0);
    endtask

    // One complete operation through the 16-bit instance.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez, input logic en);
        int lat;
        start_op(av, bv, cv);
        check({tag, ".busy"}, 32'(in_ready), 32'd0);
        wait_done(lat);
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check_result(tag, es, ec, eo, ez, en);
        ack(tag);
    endtask

    initial begin
        int lat;
        int first_hit;
        int second_hit;
        int hits;

        rst = 1'b1;
        a = '0; b = '0; ctrl = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a1 = '0; b1 = '0; ctrl1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Signed overflow on add, borrow-free subtract with overflow, plain subtract
`ifdef ADDSUB_SATURATE_EN
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("ripple", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("mixed", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap to zero, then back-pressure with a stray in_valid
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        check("wrap.latency", 32'(lat), 32'd4);
        check_result("wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold.sum", 32'(sum), 32'h0000);
            check("hold.out_valid", 32'(out_valid), 32'd1);
            check("hold.in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check_result("hold", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        ack("hold");
        check("hold.no_accept", 32'(out_valid), 32'd0);

        // Reset during the second RUN cycle
        start_op(16'h0F0F, 16'h0101, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check_result("midrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step();
        check("midrst.no_output", 32'(out_valid), 32'd0);
        run_op("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-chunk 32-bit configuration: wrap and latency
        a1 = 32'hFFFF_FFFF; b1 = 32'h0000_0001; ctrl1 = 1'b0; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 20) begin
            step();
            lat++;
        end
        check("w32.latency", 32'(lat), 32'd1);
        check("w32.sum", sum1, 32'h0000_0000);
        check("w32.c", 32'(c1), 32'd1);
        check("w32.z", 32'(z1), 32'd1);
        check("w32.o", 32'(o1), 32'd0);
        or1 = 1'b1;
        step();
        or1 = 1'b0;
        check("w32.ack_ready", 32'(ir1), 32'd1);

        // Back-to-back with both sides always ready: results every 3 cycles
        a1 = 32'h1234_5678; b1 = 32'h1111_1111; iv1 = 1'b1; or1 = 1'b1;
        first_hit = -1; second_hit = -1; hits = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ov1) begin
                if (hits == 0) first_hit = k;
                if (hits == 1) second_hit = k;
                hits++;
            end
        end
        iv1 = 1'b0; or1 = 1'b0;
        check("b2b.first", 32'(first_hit), 32'd1);
        check("b2b.spacing", 32'(second_hit - first_hit), 32'd3);
        check("b2b.sum", sum1, 32'h2345_6789);
        check("b2b.hits", 32'(hits), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_serial_nbit.md
Name: addsub_serial_nbit

Overview:
- Parametrised successor of the team's 16-bit add/sub unit.
- Adds or subtracts two WIDTH-bit two's-complement operands, CHUNK bits per clock, with a carry held in a register between chunks.
- Uses valid/ready handshakes on input and output, and reports carry, signed overflow, zero and negative flags.
- Sits between the operand register file and the result writeback stage, where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be at least 2.
- CHUNK, 4, bits processed per cycle; WIDTH % CHUNK must equal 0 (elaboration-time check, fatal on violation).
- NCHUNK, WIDTH/CHUNK, derived constant; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- A  input  WIDTH  operand A, sampled on input handshake.
- B  input  WIDTH  operand B, sampled on input handshake.
- Add_ctrl  input  1  1 = A-B, 0 = A+B; sampled on input handshake.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- SUM  output  WIDTH  result, held stable while out_valid=1.
- C_out  output  1  carry out of the MSB of A + (B xor {WIDTH{Add_ctrl}}) + Add_ctrl; for subtract, 1 = no borrow.
- O  output  1  signed overflow.
- Z  output  1  SUM equals zero.
- N  output  1  SUM[WIDTH-1].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset: single clock and synchronous active-high reset.
  - rst=1 at a rising edge forces: state=IDLE, in_ready=1, out_valid=0, SUM=0, C_out=0, O=0, Z=0, N=0.
  - Operand, carry and chunk-index registers are cleared.
  - Reset overrides every other event, including reset arriving mid-operation: any in-flight operation is discarded and no output is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid=1 at an edge: latch A, B and Add_ctrl; carry := Add_ctrl; idx := 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge computes chunk idx: {c, SUM[idx*CHUNK +: CHUNK]} = A_chunk + (B_chunk xor Add_ctrl) + carry. Then carry := c and idx := idx+1.
  - On the edge that processes idx = NCHUNK-1:
    - Set C_out to the final carry.
    - Set O = (A_msb == B_eff_msb) && (SUM_msb != A_msb), where B_eff = B xor {WIDTH{Add_ctrl}}.
    - Set Z and N from the final SUM.
    - Go to DONE.
- DONE:
  - out_valid=1; in_ready=0.
  - If out_ready=1 at an edge, go to IDLE and drop out_valid.
  - Outputs hold their values until the next result completes.
- Latency: operands accepted at edge E0; out_valid=1 after edge E(NCHUNK). Throughput: one result per NCHUNK+2 cycles with out_ready held at 1.
- in_valid while not IDLE is ignored. The producer must hold its data until in_ready=1.
- Partial SUM bits may be visible during RUN; consumers use SUM only when out_valid=1.
- NCHUNK=1 (CHUNK=WIDTH) is legal: RUN lasts exactly one cycle.
- Wrap-around is modulo 2^WIDTH, e.g. max+1 gives 0 with C_out=1.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- When defined: if O=1 on completion, SUM is replaced by the saturation limit.
  - 0 followed by ones (most positive) if A_msb=0.
  - 1 followed by zeros (most negative) if A_msb=1.
  - O still reports 1; Z and N follow the saturated SUM.
  - Replacement happens on the final RUN edge; latency is unchanged.
- When undefined: SUM wraps; no extra logic.

Decomposition:
- Shared package addsub_pkg:
  - state enum (IDLE, RUN, DONE).
  - function computing the overflow expression.
  - saturation-limit constant functions parametrised by width.
- One sub-module: addsub_chunk, a combinational CHUNK-bit adder with inputs a, b, inv, cin and outputs s, cout. It is instantiated once and reused every RUN cycle.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- 0x7FFF + 0x0001 (Add_ctrl=0) -> SUM=0x8000, C_out=0, O=1, N=1, Z=0; out_valid exactly 4 edges after acceptance.
- 0x8000 - 0x0001 (Add_ctrl=1) -> SUM=0x7FFF, C_out=1, O=1. A second case, 0x0005 - 0x0007 -> SUM=0xFFFE, C_out=0, O=0, N=1.
- 0xFFFF + 0x0001 -> SUM=0x0000, C_out=1, O=0, Z=1. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, and a new in_valid is ignored.
- Assert rst at the 2nd RUN cycle -> next cycle state=IDLE, in_ready=1, out_valid=0, all flags 0; the following operation 0x0003+0x0004 returns 0x0007.
- With ADDSUB_SATURATE_EN defined: 0x7FFF+0x0001 -> SUM=0x7FFF, O=1; 0x8000-0x0001 -> SUM=0x8000, O=1.
- WIDTH=32, CHUNK=32: 0xFFFFFFFF+0x00000001 -> SUM=0, C_out=1, out_valid after 1 RUN edge; back-to-back ops spaced at NCHUNK+2 = 3 cycles.
